// File: rtl/i2s_tx.sv
// I2S transmitter: one-entry stereo holding buffer feeding a standard I2S
// serializer (MSB first, one delay bit after each word-select change).
module i2s_tx #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned SLOT_W    = 32,
  parameter int unsigned SCLK_HALF = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_left,
  input  logic [DATA_W-1:0] s_right,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              i2s_sclk,
  output logic              i2s_lrck,
  output logic              i2s_sdata,
  output logic              frame_start,
  output logic              underrun
);

  localparam int unsigned FrameBits = 2 * SLOT_W;
  localparam int unsigned DivW      = $clog2(SCLK_HALF);
  localparam int unsigned BitW      = $clog2(FrameBits);

  logic [DivW-1:0]   div_cnt_q;
  logic [BitW-1:0]   bit_cnt_q;
  logic              buf_full_q;
  logic [DATA_W-1:0] buf_left_q, buf_right_q;
  logic [DATA_W-1:0] frame_left_q, frame_right_q;
  logic              sclk_q, lrck_q, sdata_q, frame_start_q, underrun_q;

  logic [BitW-1:0]   bit_nxt;
  logic              lrck_nxt, sdata_nxt;
  logic [DATA_W-1:0] word, shifted;
  int unsigned       k;

  assign s_ready     = ~buf_full_q & ~rst;
  assign i2s_sclk    = sclk_q;
  assign i2s_lrck    = lrck_q;
  assign i2s_sdata   = sdata_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;

  // Frame position and serial bit for the SCLK period that starts at the next falling edge.
  always_comb begin
    bit_nxt   = (bit_cnt_q == BitW'(FrameBits - 1)) ? '0 : bit_cnt_q + 1'b1;
    k         = 32'(bit_nxt);
    lrck_nxt  = (k >= SLOT_W);
    word      = lrck_nxt ? frame_right_q : frame_left_q;
    if (k >= SLOT_W) k = k - SLOT_W;
    shifted   = '0;
    sdata_nxt = 1'b0;
    // Slot position 0 is the I2S delay bit; frame regs only change at position 0.
    if (k >= 1 && k <= DATA_W) begin
      shifted   = word >> (DATA_W - k);
      sdata_nxt = shifted[0];
    end
  end

  // Buffer handshake, SCLK divider, frame sequencing and registered I2S outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q     <= '0;
      bit_cnt_q     <= BitW'(FrameBits - 1);
      buf_full_q    <= 1'b0;
      buf_left_q    <= '0;
      buf_right_q   <= '0;
      frame_left_q  <= '0;
      frame_right_q <= '0;
      sclk_q        <= 1'b0;
      lrck_q        <= 1'b0;
      sdata_q       <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      if (s_valid && s_ready) begin
        buf_left_q  <= s_left;
        buf_right_q <= s_right;
        buf_full_q  <= 1'b1;
      end
      if (div_cnt_q == DivW'(SCLK_HALF - 1)) begin
        div_cnt_q <= '0;
        sclk_q    <= ~sclk_q;
        if (sclk_q) begin
          bit_cnt_q <= bit_nxt;
          lrck_q    <= lrck_nxt;
          sdata_q   <= sdata_nxt;
          if (bit_nxt == '0) begin
            frame_start_q <= 1'b1;
            // A write cannot coincide with a full buffer, so clearing here is safe.
            if (buf_full_q) begin
              frame_left_q  <= buf_left_q;
              frame_right_q <= buf_right_q;
              buf_full_q    <= 1'b0;
            end else begin
              frame_left_q  <= '0;
              frame_right_q <= '0;
              underrun_q    <= 1'b1;
            end
          end
        end
      end else begin
        div_cnt_q <= div_cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: randomized pairs against a timing/frame model derived from
// elapsed cycles since reset, plus a clocking check on a SCLK_HALF=18 instance.
module tb_i2s_tx;

  localparam int SH    = 2;
  localparam int SH2   = 18;
  localparam int SLOT  = 32;
  localparam int DW    = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] s_left = '0, s_right = '0;
  logic s_valid = 1'b0;
  logic s_ready, i2s_sclk, i2s_lrck, i2s_sdata, frame_start, underrun;

  logic [15:0] zero_word = '0;
  logic zero_valid = 1'b0;
  logic s_ready2, sclk2, lrck2, sdata2, fs2, ur2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  i2s_tx #(.DATA_W(16), .SLOT_W(32), .SCLK_HALF(SH)) dut (
    .clk(clk), .rst(rst), .s_left(s_left), .s_right(s_right), .s_valid(s_valid),
    .s_ready(s_ready), .i2s_sclk(i2s_sclk), .i2s_lrck(i2s_lrck), .i2s_sdata(i2s_sdata),
    .frame_start(frame_start), .underrun(underrun)
  );

  i2s_tx #(.DATA_W(16), .SLOT_W(32), .SCLK_HALF(SH2)) dut_slow (
    .clk(clk), .rst(rst), .s_left(zero_word), .s_right(zero_word), .s_valid(zero_valid),
    .s_ready(s_ready2), .i2s_sclk(sclk2), .i2s_lrck(lrck2), .i2s_sdata(sdata2),
    .frame_start(fs2), .underrun(ur2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: t counts cycles since reset release; SCLK falls every 2*SH cycles.
  int t = 0;
  bit mvalid = 1'b0, m_full = 1'b0, prev_rst = 1'b0, prev_acc = 1'b0;
  logic [15:0] m_bl = '0, m_br = '0, m_fl = '0, m_fr = '0, prev_l = '0, prev_r = '0;

  always @(negedge clk) begin : model
    int nf, p, kk;
    bit bnd, exp_ur, exp_lr, exp_sd, exp_rdy;
    logic [15:0] w;
    bnd = 1'b0;
    exp_ur = 1'b0;
    if (prev_rst) begin
      t = 0; m_full = 1'b0; m_fl = '0; m_fr = '0; mvalid = 1'b1;
    end else if (mvalid) begin
      t++;
      nf = t / (2 * SH);
      bnd = (t % (2 * SH) == 0) && ((nf - 1) % (2 * SLOT) == 0);
      if (bnd) begin
        if (m_full) begin m_fl = m_bl; m_fr = m_br; m_full = 1'b0; end
        else begin m_fl = '0; m_fr = '0; exp_ur = 1'b1; end
      end
      if (prev_acc) begin m_full = 1'b1; m_bl = prev_l; m_br = prev_r; end
    end
    exp_rdy = !m_full && !rst;
    if (mvalid) begin
      nf = t / (2 * SH);
      exp_lr = 1'b0;
      exp_sd = 1'b0;
      if (nf > 0) begin
        p = (nf - 1) % (2 * SLOT);
        exp_lr = (p >= SLOT);
        kk = p % SLOT;
        w = exp_lr ? m_fr : m_fl;
        if (kk >= 1 && kk <= DW) exp_sd = w[DW - kk];
      end
      check("sclk", 32'(i2s_sclk), 32'((t / SH) % 2));
      check("lrck", 32'(i2s_lrck), 32'(exp_lr));
      check("sdata", 32'(i2s_sdata), 32'(exp_sd));
      check("frame_start", 32'(frame_start), 32'(bnd));
      check("underrun", 32'(underrun), 32'(exp_ur));
      check("s_ready", 32'(s_ready), 32'(exp_rdy));
    end
    prev_acc = s_valid && exp_rdy;
    prev_l   = s_left;
    prev_r   = s_right;
    prev_rst = rst;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst(input int n);
    @(posedge clk); #1 rst = 1'b1;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send(input logic [15:0] l, input logic [15:0] r);
    bit got;
    got = 1'b0;
    s_left = l; s_right = r; s_valid = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (s_ready) begin got = 1'b1; break; end
    end
    @(posedge clk); #1 s_valid = 1'b0;
    if (!got) check("handshake_timeout", 32'(got), 32'd1);
  endtask

  task automatic wait_sig(input string tag, input int which);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if ((which == 0 && frame_start) || (which == 1 && i2s_lrck)) begin seen = 1'b1; break; end
    end
    if (!seen) check(tag, 32'(seen), 32'd1);
  endtask

  initial begin : stim
    int last_tog, last_fs, cyc;
    bit prev_sclk;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(300);                         // empty buffer: underrun frame of zeros
    pulse_rst(1);
    send(16'h8001, 16'h7FFE);          // loaded at the first boundary
    send(16'h1234, 16'hABCD);
    send(16'hFFFF, 16'h0000);
    idle(600);                         // starvation after last pair
    for (int n = 0; n < 25; n++) begin
      send(16'($urandom), 16'($urandom));
      idle($urandom_range(0, 400));
    end
    // Reset mid right slot with a pair waiting in the buffer.
    send(16'h5A5A, 16'hC3C3);
    wait_sig("wait_frame_start", 0);
    idle(1);
    send(16'h0F0F, 16'hF0F0);
    idle(20);
    wait_sig("wait_lrck_high", 1);
    idle(10);
    pulse_rst(1);
    idle(600);

    // Clocking on the SCLK_HALF=18 instance.
    pulse_rst(2);
    last_tog = -1; last_fs = -1; prev_sclk = 1'b0;
    for (cyc = 0; cyc < 2000 * SH2 + 10; cyc++) begin
      @(negedge clk);
      if (sclk2 != prev_sclk) begin
        if (last_tog < 0) check("sclk18_first_rise", 32'(cyc), 32'(SH2));
        else check("sclk18_phase", 32'(cyc - last_tog), 32'(SH2));
        last_tog = cyc;
        prev_sclk = sclk2;
      end
      if (fs2) begin
        if (last_fs >= 0) check("frame18_spacing", 32'(cyc - last_fs), 32'd2304);
        last_fs = cyc;
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
